// File: rtl/turn_pkg.sv
// Shared types and constants for the two-player turn sequencer.
package turn_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        PLAY = 3'd2,
        AUTO = 3'd3,
        OVER = 3'd4
    } turn_state_t;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    function automatic logic [1:0] win_code(input logic player);
        return (player == P2) ? WIN_P2 : WIN_P1;
    endfunction

endpackage

// File: rtl/turn_controller_strike_counter.sv
// Per-player consecutive-timeout counter, saturating at MAX_STRIKES.
// limit means the next strike reaches MAX_STRIKES (i.e. forfeits).
module strike_counter #(
    parameter int MAX_STRIKES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] count,
    output logic       limit
);
    localparam logic [3:0] MAX = 4'(MAX_STRIKES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= 4'd0;
        else if (clr)
            count <= 4'd0;
        else if (inc && (count != MAX))
            count <= count + 4'd1;
    end

    assign limit = (count == (MAX - 4'd1));

endmodule

// File: rtl/turn_controller.sv
// Two-player turn sequencer driving the 10-second turn timer.
// Optional auto-move on timeout is built when TURN_AUTO_MOVE_EN is defined.
//
// state | meaning
// IDLE  | no game; timer held in reset
// ARM   | one cycle of timer reset before a turn
// PLAY  | turn in progress; timer running
// AUTO  | turn timed out; waiting for the auto-move to land
// OVER  | game finished; winner held until start
module turn_controller
    import turn_pkg::*;
#(
    parameter int MAX_STRIKES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       move_done,
    input  logic       game_won,
    input  logic       timeout,
    output logic       timer_enable,
    output logic       timer_reset,
    output logic       current_player,
    output logic       auto_move,
    output logic [1:0] winner,
    output logic [3:0] strikes_p1,
    output logic [3:0] strikes_p2,
    output logic [7:0] turn_count,
    output logic [2:0] state
);
    turn_state_t state_q, state_next;
    logic        player_next;
    logic [1:0]  win_next;
    logic        game_clr, turn_inc, clr_mover, inc_mover;
    logic        limit_p1, limit_p2, mover_limit;

    assign mover_limit = (current_player == P1) ? limit_p1 : limit_p2;

    always_comb begin
        state_next  = state_q;
        player_next = current_player;
        win_next    = winner;
        game_clr    = 1'b0;
        turn_inc    = 1'b0;
        clr_mover   = 1'b0;
        inc_mover   = 1'b0;
        unique case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_next  = ARM;
                    player_next = P1;
                    win_next    = WIN_NONE;
                    game_clr    = 1'b1;
                end
            end
            ARM: state_next = PLAY;
            PLAY: begin
                if (move_done && game_won) begin
                    state_next = OVER;
                    win_next   = win_code(current_player);
                end else if (move_done) begin
                    clr_mover   = 1'b1;
                    player_next = ~current_player;
                    turn_inc    = 1'b1;
                    state_next  = ARM;
                end else if (timeout) begin
                    inc_mover = 1'b1;
                    if (mover_limit) begin
                        state_next = OVER;
                        win_next   = win_code(~current_player);
                    end else begin
`ifdef TURN_AUTO_MOVE_EN
                        state_next = AUTO;
`else
                        player_next = ~current_player;
                        turn_inc    = 1'b1;
                        state_next  = ARM;
`endif
                    end
                end
            end
`ifdef TURN_AUTO_MOVE_EN
            // The auto-move never forgives strikes; only a real move does.
            AUTO: begin
                if (move_done && game_won) begin
                    state_next = OVER;
                    win_next   = win_code(current_player);
                end else if (move_done) begin
                    player_next = ~current_player;
                    turn_inc    = 1'b1;
                    state_next  = ARM;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            current_player <= P1;
            winner         <= WIN_NONE;
            turn_count     <= 8'd0;
        end else begin
            state_q        <= state_next;
            current_player <= player_next;
            winner         <= win_next;
            if (game_clr)
                turn_count <= 8'd0;
            else if (turn_inc && (turn_count != 8'hFF))
                turn_count <= turn_count + 8'd1;
        end
    end

`ifdef TURN_AUTO_MOVE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            auto_move <= 1'b0;
        else
            auto_move <= (state_q == PLAY) && (state_next == AUTO);
    end
`else
    assign auto_move = 1'b0;
`endif

    assign timer_enable = (state_q == PLAY);
    assign timer_reset  = (state_q == IDLE) || (state_q == ARM) || (state_q == OVER);
    assign state        = state_q;

    strike_counter #(.MAX_STRIKES(MAX_STRIKES)) u_strikes_p1 (
        .clk   (clk),
        .rst   (rst),
        .clr   (game_clr || (clr_mover && (current_player == P1))),
        .inc   (inc_mover && (current_player == P1)),
        .count (strikes_p1),
        .limit (limit_p1)
    );

    strike_counter #(.MAX_STRIKES(MAX_STRIKES)) u_strikes_p2 (
        .clk   (clk),
        .rst   (rst),
        .clr   (game_clr || (clr_mover && (current_player == P2))),
        .inc   (inc_mover && (current_player == P2)),
        .count (strikes_p2),
        .limit (limit_p2)
    );

endmodule

// File: tb/tb_turn_controller.sv
// Directed self-checking bench for turn_controller (MAX_STRIKES = 3).
// Follows TURN_AUTO_MOVE_EN so both builds are exercised with the same scenarios.
module tb_turn_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, move_done = 1'b0, game_won = 1'b0, timeout = 1'b0;
    logic       timer_enable, timer_reset, current_player, auto_move;
    logic [1:0] winner;
    logic [3:0] strikes_p1, strikes_p2;
    logic [7:0] turn_count;
    logic [2:0] state;
    int vectors = 0;
    int miscompares = 0;

    turn_controller #(.MAX_STRIKES(3)) dut (
        .clk(clk), .rst(rst), .start(start), .move_done(move_done), .game_won(game_won),
        .timeout(timeout), .timer_enable(timer_enable), .timer_reset(timer_reset),
        .current_player(current_player), .auto_move(auto_move), .winner(winner),
        .strikes_p1(strikes_p1), .strikes_p2(strikes_p2), .turn_count(turn_count), .state(state)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Current player commits a move; returns in PLAY with the other player up.
    task automatic move_turn();
        move_done = 1'b1;
        cycle();
        move_done = 1'b0;
        cycle();
    endtask

    // Current player times out (non-final strike); returns in PLAY with the other player up.
    task automatic timeout_turn();
        timeout = 1'b1;
        cycle();
`ifdef TURN_AUTO_MOVE_EN
        timeout = 1'b0;
        move_done = 1'b1;
        cycle();
        move_done = 1'b0;
`else
        timeout = 1'b0;
`endif
        cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cycle();
        vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state); end
        vectors++; if (timer_reset !== 1'b1 || timer_enable !== 1'b0) begin miscompares++; $display("FAIL reset_timer: got rst=%b en=%b want 1 0", timer_reset, timer_enable); end
        vectors++; if ({winner, strikes_p1, strikes_p2, turn_count, current_player, auto_move} !== 20'd0) begin miscompares++; $display("FAIL reset_regs: win=%b s1=%0d s2=%0d tc=%0d cp=%b am=%b want all 0", winner, strikes_p1, strikes_p2, turn_count, current_player, auto_move); end
    endtask

    task automatic test_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
        vectors++; if (state !== 3'd1 || timer_reset !== 1'b1 || timer_enable !== 1'b0) begin miscompares++; $display("FAIL start_arm: got st=%0d rst=%b en=%b want 1 1 0", state, timer_reset, timer_enable); end
        cycle();
        vectors++; if (state !== 3'd2 || timer_enable !== 1'b1 || timer_reset !== 1'b0) begin miscompares++; $display("FAIL start_play: got st=%0d en=%b rst=%b want 2 1 0", state, timer_enable, timer_reset); end
        vectors++; if (current_player !== 1'b0) begin miscompares++; $display("FAIL start_player: got %b want 0", current_player); end
    endtask

    task automatic test_move();
        move_done = 1'b1;
        cycle();
        move_done = 1'b0;
        vectors++; if (state !== 3'd1 || current_player !== 1'b1 || timer_reset !== 1'b1) begin miscompares++; $display("FAIL move_arm: got st=%0d cp=%b rst=%b want 1 1 1", state, current_player, timer_reset); end
        vectors++; if (turn_count !== 8'd1 || strikes_p1 !== 4'd0) begin miscompares++; $display("FAIL move_counts: got tc=%0d s1=%0d want 1 0", turn_count, strikes_p1); end
        cycle();
        vectors++; if (state !== 3'd2 || timer_enable !== 1'b1) begin miscompares++; $display("FAIL move_play: got st=%0d en=%b want 2 1", state, timer_enable); end
    endtask

    task automatic test_timeout();
        move_turn();
        timeout = 1'b1;
        cycle();
`ifdef TURN_AUTO_MOVE_EN
        vectors++; if (state !== 3'd3 || auto_move !== 1'b1 || timer_enable !== 1'b0) begin miscompares++; $display("FAIL to_auto: got st=%0d am=%b en=%b want 3 1 0", state, auto_move, timer_enable); end
        vectors++; if (strikes_p1 !== 4'd1) begin miscompares++; $display("FAIL to_strike1: got %0d want 1", strikes_p1); end
        cycle();
        vectors++; if (state !== 3'd3 || auto_move !== 1'b0 || strikes_p1 !== 4'd1) begin miscompares++; $display("FAIL to_hold: got st=%0d am=%b s1=%0d want 3 0 1", state, auto_move, strikes_p1); end
        timeout = 1'b0;
        move_done = 1'b1;
        cycle();
        move_done = 1'b0;
        vectors++; if (state !== 3'd1 || current_player !== 1'b1) begin miscompares++; $display("FAIL to_handoff: got st=%0d cp=%b want 1 1", state, current_player); end
        vectors++; if (strikes_p1 !== 4'd1 || turn_count !== 8'd3) begin miscompares++; $display("FAIL to_counts: got s1=%0d tc=%0d want 1 3", strikes_p1, turn_count); end
        cycle();
`else
        vectors++; if (state !== 3'd1 || current_player !== 1'b1 || auto_move !== 1'b0) begin miscompares++; $display("FAIL to_handoff: got st=%0d cp=%b am=%b want 1 1 0", state, current_player, auto_move); end
        vectors++; if (strikes_p1 !== 4'd1 || turn_count !== 8'd3) begin miscompares++; $display("FAIL to_counts: got s1=%0d tc=%0d want 1 3", strikes_p1, turn_count); end
        cycle();
        timeout = 1'b0;
        vectors++; if (state !== 3'd2 || strikes_p1 !== 4'd1) begin miscompares++; $display("FAIL to_hold: got st=%0d s1=%0d want 2 1", state, strikes_p1); end
`endif
    endtask

    task automatic test_forfeit();
        move_turn();
        timeout_turn();
        vectors++; if (strikes_p1 !== 4'd2 || current_player !== 1'b1 || turn_count !== 8'd5) begin miscompares++; $display("FAIL ff_second: got s1=%0d cp=%b tc=%0d want 2 1 5", strikes_p1, current_player, turn_count); end
        move_turn();
        timeout = 1'b1;
        cycle();
        timeout = 1'b0;
        vectors++; if (state !== 3'd4 || winner !== 2'b10) begin miscompares++; $display("FAIL ff_over: got st=%0d win=%b want 4 10", state, winner); end
        vectors++; if (timer_enable !== 1'b0 || timer_reset !== 1'b1 || strikes_p1 !== 4'd3 || auto_move !== 1'b0) begin miscompares++; $display("FAIL ff_outputs: got en=%b rst=%b s1=%0d am=%b want 0 1 3 0", timer_enable, timer_reset, strikes_p1, auto_move); end
        move_done = 1'b1;
        cycle();
        move_done = 1'b0;
        vectors++; if (state !== 3'd4 || turn_count !== 8'd6 || winner !== 2'b10) begin miscompares++; $display("FAIL ff_ignore: got st=%0d tc=%0d win=%b want 4 6 10", state, turn_count, winner); end
    endtask

    task automatic test_same_cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        vectors++; if (winner !== 2'b00 || strikes_p1 !== 4'd0 || turn_count !== 8'd0 || state !== 3'd2) begin miscompares++; $display("FAIL restart: got win=%b s1=%0d tc=%0d st=%0d want 00 0 0 2", winner, strikes_p1, turn_count, state); end
        move_done = 1'b1;
        timeout = 1'b1;
        cycle();
        move_done = 1'b0;
        timeout = 1'b0;
        vectors++; if (state !== 3'd1 || current_player !== 1'b1 || strikes_p1 !== 4'd0 || turn_count !== 8'd1) begin miscompares++; $display("FAIL same_cycle: got st=%0d cp=%b s1=%0d tc=%0d want 1 1 0 1", state, current_player, strikes_p1, turn_count); end
        cycle();
        move_done = 1'b1;
        game_won = 1'b1;
        cycle();
        move_done = 1'b0;
        game_won = 1'b0;
        vectors++; if (state !== 3'd4 || winner !== 2'b10 || turn_count !== 8'd1) begin miscompares++; $display("FAIL p2_wins: got st=%0d win=%b tc=%0d want 4 10 1", state, winner, turn_count); end
    endtask

    task automatic test_saturate();
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        for (int i = 0; i < 256; i++) move_turn();
        vectors++; if (turn_count !== 8'd255 || state !== 3'd2) begin miscompares++; $display("FAIL turn_saturate: got tc=%0d st=%0d want 255 2", turn_count, state); end
    endtask

    task automatic test_async_reset();
        timeout = 1'b1;
        #2 rst = 1'b1;
        #1;
        vectors++; if (state !== 3'd0 || timer_reset !== 1'b1 || timer_enable !== 1'b0) begin miscompares++; $display("FAIL async_state: got st=%0d rst=%b en=%b want 0 1 0", state, timer_reset, timer_enable); end
        vectors++; if (turn_count !== 8'd0 || strikes_p1 !== 4'd0 || strikes_p2 !== 4'd0 || current_player !== 1'b0 || auto_move !== 1'b0) begin miscompares++; $display("FAIL async_regs: got tc=%0d s1=%0d s2=%0d cp=%b am=%b want 0", turn_count, strikes_p1, strikes_p2, current_player, auto_move); end
        @(negedge clk);
        rst = 1'b0;
        cycle();
        timeout = 1'b0;
        vectors++; if (state !== 3'd0 || strikes_p1 !== 4'd0) begin miscompares++; $display("FAIL async_idle: got st=%0d s1=%0d want 0 0", state, strikes_p1); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_move();
        test_timeout();
        test_forfeit();
        test_same_cycle();
        test_saturate();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/turn_controller.md
# turn_controller

Two-player turn sequencer that sits directly downstream of the 10-second turn timer and also drives it. It consumes the timer's `timeout` level and the board logic's move and win strobes. It produces `enable`/`reset_timer` for the timer, the active player, forfeit strikes and the winner. On a timeout it optionally requests an automatic move from the board logic.

## Interface
- `MAX_STRIKES`, default 3: consecutive timeouts by one player that cause forfeit; legal range 1..15.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous reset, active-high.
- `start` in 1: one-cycle pulse that begins or restarts a game; honoured only in IDLE and OVER.
- `move_done` in 1: one-cycle pulse; the current player (or the auto-move) committed a move.
- `game_won` in 1: qualifies `move_done`; that move ended the game for the mover.
- `timeout` in 1: timer timeout level; high until the timer is reset.
- `timer_enable` out 1: drives timer `enable`.
- `timer_reset` out 1: drives timer `reset_timer`.
- `current_player` out 1: 0 = P1, 1 = P2.
- `auto_move` out 1: one-cycle request for the board logic to play a random move.
- `winner` out 2: 00 none, 01 P1, 10 P2.
- `strikes_p1`, `strikes_p2` out 4 each: consecutive-timeout counts.
- `turn_count` out 8: completed handoffs, saturating at 255.
- `state` out 3: debug copy of the FSM state encoding.

## Operation
- States: IDLE, ARM, PLAY, AUTO, OVER.
- IDLE:
  - `timer_reset`=1, `timer_enable`=0.
  - `start` -> ARM with `current_player`=0, strikes=0, `turn_count`=0, `winner`=00.
- ARM (exactly 1 cycle): `timer_reset`=1, `timer_enable`=0 -> PLAY.
- PLAY: `timer_enable`=1, `timer_reset`=0. Priority order:
  1. `move_done` & `game_won` -> OVER; `winner` = current player.
  2. `move_done` -> clear the mover's strikes, toggle player, increment `turn_count` -> ARM.
  3. `timeout` -> increment the mover's strikes.
     - If the new value == `MAX_STRIKES`: OVER; `winner` = other player.
     - Else: AUTO (or the handoff of step 2, without the strike clear, when auto-move is compiled out).
- AUTO:
  - `timer_enable`=0.
  - `auto_move`=1 on the first AUTO cycle only.
  - Waits for `move_done`, then applies PLAY rules 1–2, except that strikes are NOT cleared.
- OVER:
  - `timer_enable`=0, `timer_reset`=1; `winner` held.
  - `start` -> same as `start` in IDLE.
- `move_done`/`game_won`/`timeout` are ignored outside PLAY (and AUTO for `move_done`). `start` is ignored in ARM, PLAY and AUTO.
- Strike counters never exceed `MAX_STRIKES`. `turn_count` saturates and does not wrap.

## Timing
- All state and outputs are registered or decoded from the state register; no input-to-output combinational path.
- Reset values: state IDLE, `current_player` 0, `winner` 00, strikes 0, `turn_count` 0, `timer_enable` 0, `timer_reset` 1, `auto_move` 0.
- `rst` mid-game forces the reset values asynchronously; no pending event survives.
- Event sampled in PLAY at cycle N:
  - Cycle N+1: ARM with toggled `current_player` and `timer_reset`=1.
  - Cycle N+2: PLAY with `timer_enable`=1.
- `timeout` at cycle N -> AUTO at N+1, `auto_move` high at N+1 only.
- Leaving PLAY on `timeout` guarantees one strike per timeout, even though `timeout` stays high until the ARM reset.
- `move_done` and `timeout` in the same cycle: the move wins; no strike is recorded.

## Configuration
- `TURN_AUTO_MOVE_EN` defined:
  - The AUTO state exists.
  - A timeout requests a random move via `auto_move`, and the turn passes after that move's `move_done`.
- Not defined:
  - No AUTO state; `auto_move` is tied 0.
  - A timeout passes the turn directly through ARM; strikes are still counted.

## Structure
- Shared package `turn_pkg`:
  - `turn_state_t` enum with fixed 3-bit encodings IDLE=0, ARM=1, PLAY=2, AUTO=3, OVER=4.
  - Player constants `P1`=0, `P2`=1.
  - Winner codes `WIN_NONE`, `WIN_P1`, `WIN_P2`.
- One sub-module `strike_counter`, instantiated twice (one per player): clear, increment, saturate at `MAX_STRIKES`, `limit` flag.

## Test plan
- Reset, then `start` -> one ARM cycle with `timer_reset`=1, then PLAY with `timer_enable`=1, `current_player`=0.
- `move_done` in PLAY -> next cycle `current_player`=1, `timer_reset` pulse, `turn_count`=1, `strikes_p1`=0.
- With `TURN_AUTO_MOVE_EN`: `timeout` held high in PLAY -> `strikes_p1`=1 (not 2), `auto_move` 1-cycle pulse; `move_done` -> `current_player`=1.
- `MAX_STRIKES`=3, P1 times out 3 consecutive turns (P2 moves in between) -> OVER, `winner`=10, `timer_enable`=0.
- `move_done` and `timeout` in the same cycle -> no strike, player toggles. `move_done`+`game_won` by P2 -> `winner`=10.
- `rst` asserted asynchronously mid-PLAY -> IDLE, `timer_reset`=1, all counters 0 before the next clock edge.
